// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//
// Shares one combinational 32-bit ALU between two requesters. Requests are
// granted round-robin, their operands are registered and presented to the ALU
// for one cycle, and the ALU result/flags are captured into a per-requester
// response register that holds until the requester accepts it.
//
// Parameters:
//   FIRST_PRIO   requester (0 or 1) that wins the first tie after reset
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/ready, req1_valid/ready
//                                   request handshakes
//   req0_a/b/sel, req1_a/b/sel      operands and 4-bit ALU select
//   rsp0_valid/ready, rsp1_valid/ready
//                                   response handshakes
//   rsp0_result/flags, rsp1_result/flags
//                                   captured ALU result and {ov, carry, zero}
//   alu_a, alu_b, alu_sel           registered operands driven to the ALU
//   alu_out, alu_carry, alu_overflow, alu_zero
//                                   combinational ALU outputs
//   busy                            high whenever a request is in flight
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int unsigned FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_sel,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_sel,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic [2:0]  rsp0_flags,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic [2:0]  rsp1_flags,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,

    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_t;

    state_t state;
    logic   owner;       // requester whose operation is in flight
    logic   last_grant;  // requester granted most recently

    logic   grant;
    logic   any_valid;
    logic   owner_rsp_ready;

    // Grant selection: a lone requester wins; on a tie the requester that was
    // not granted last wins.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    // Ready is forced low while reset is asserted so that no handshake can be
    // seen by a requester while the block is being cleared.
    always_comb begin
        req0_ready = rst_n && (state == StIdle) && req0_valid && !grant;
        req1_ready = rst_n && (state == StIdle) && req1_valid && grant;
    end

    always_comb begin
        owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            owner       <= 1'b0;
            last_grant  <= (FIRST_PRIO == 0);
            busy        <= 1'b0;
            alu_a       <= 32'h0;
            alu_b       <= 32'h0;
            alu_sel     <= 4'h0;
            rsp0_valid  <= 1'b0;
            rsp0_result <= 32'h0;
            rsp0_flags  <= 3'b000;
            rsp1_valid  <= 1'b0;
            rsp1_result <= 32'h0;
            rsp1_flags  <= 3'b000;
        end else begin
            unique case (state)
                StIdle: begin
                    // Any valid in IDLE is a handshake with the granted side.
                    if (any_valid) begin
                        owner   <= grant;
                        busy    <= 1'b1;
                        alu_a   <= grant ? req1_a   : req0_a;
                        alu_b   <= grant ? req1_b   : req0_b;
                        alu_sel <= grant ? req1_sel : req0_sel;
                        state   <= StExec;
                    end
                end

                StExec: begin
                    // ALU has seen the latched operands for the whole cycle.
                    if (owner) begin
                        rsp1_result <= alu_out;
                        rsp1_flags  <= {alu_overflow, alu_carry, alu_zero};
                        rsp1_valid  <= 1'b1;
                    end else begin
                        rsp0_result <= alu_out;
                        rsp0_flags  <= {alu_overflow, alu_carry, alu_zero};
                        rsp0_valid  <= 1'b1;
                    end
                    last_grant <= owner;
                    state      <= StResp;
                end

                StResp: begin
                    if (owner_rsp_ready) begin
                        if (owner) begin
                            rsp1_valid <= 1'b0;
                        end else begin
                            rsp0_valid <= 1'b0;
                        end
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Structural invariants of the sequencer.
    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(req0_ready && req1_ready));

    a_one_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp0_valid && rsp1_valid));

    a_busy_state : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state != StIdle));

endmodule
